// File: rtl/field_line_clear_if.sv
// ---------------------------------------------------------------------------
// field_line_clear_if
//   Request/result bundle between the background register / scoring logic
//   and the line-clear engine.
//
//   start          master -> slave   single-cycle request, sampled in IDLE
//   field_in       master -> slave   ROWS*COLS playfield to compact
//   field_out      slave  -> master  compacted playfield, held until next commit
//   lines_cleared  slave  -> master  full rows removed by the last operation
//   busy           slave  -> master  operation in progress
//   done           slave  -> master  one-cycle pulse when results update
// ---------------------------------------------------------------------------
interface field_line_clear_if #(
  parameter int ROWS  = 20,
  parameter int COLS  = 20,
  parameter int CNT_W = 5
);
  logic                   start;
  logic [ROWS*COLS-1:0]   field_in;
  logic [ROWS*COLS-1:0]   field_out;
  logic [CNT_W-1:0]       lines_cleared;
  logic                   busy;
  logic                   done;

  modport master (
    output start, field_in,
    input  field_out, lines_cleared, busy, done
  );

  modport slave (
    input  start, field_in,
    output field_out, lines_cleared, busy, done
  );
endinterface

// File: rtl/field_line_clear.sv
// ---------------------------------------------------------------------------
// field_line_clear
//   Removes every completely filled row from a ROWS x COLS playfield,
//   drops the surviving rows toward the bottom and zero-fills the top.
//   One row is examined per cycle, bottom row first, so the latency from
//   the accepting edge to done is always ROWS+1 edges.
//
//   Row r lives at field bits [COLS*r +: COLS]; row 0 is the top.
//
//   Ports
//     clk    rising-edge clock
//     reset  asynchronous, active-low reset
//     bus    field_line_clear_if.slave: start/field_in in,
//            field_out/lines_cleared/busy/done out (all outputs registered)
// ---------------------------------------------------------------------------
module field_line_clear #(
  parameter int ROWS  = 20,
  parameter int COLS  = 20,
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  field_line_clear_if.slave bus
);

  localparam int N     = ROWS * COLS;
  localparam int PTR_W = $clog2(ROWS);
  // The write pointer carries one extra bit so that the decrement after a
  // write to row 0 lands outside 0..ROWS-1 instead of aliasing a real row.
  localparam int WR_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [N-1:0]      r_src;
  logic [N-1:0]      r_dst;
  logic [N-1:0]      r_field_out;
  logic [PTR_W-1:0]  r_rd;
  logic [WR_W-1:0]   r_wr;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_lines;
  logic              r_busy;
  logic              r_done;

  logic [COLS-1:0]   w_src_row;
  logic              w_row_full;
  logic              w_wr_valid;
  logic              w_accept;

  assign w_src_row  = r_src[COLS*r_rd +: COLS];
  assign w_row_full = &w_src_row;
  assign w_wr_valid = (r_wr < WR_W'(ROWS));
  assign w_accept   = (r_state == IDLE) && bus.start;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: w_next is given a default before the case so that every path
  // assigns it; a missing assignment would infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start)  w_next = SCAN;
      SCAN:    if (r_rd == '0) w_next = COMMIT;
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  // NOTE: the row buffers are ordinary flops rather than a RAM, so they are
  // cleared by reset like any other register; an aborted operation must not
  // leave a stale partial field behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_src       <= '0;
      r_dst       <= '0;
      r_field_out <= '0;
      r_rd        <= '0;
      r_wr        <= '0;
      r_cnt       <= '0;
      r_lines     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_src  <= bus.field_in;
            // Zeroing dst up front is what leaves the vacated top rows empty.
            r_dst  <= '0;
            r_rd   <= PTR_W'(ROWS - 1);
            r_wr   <= WR_W'(ROWS - 1);
            r_cnt  <= '0;
            r_busy <= 1'b1;
          end
        end
        SCAN: begin
          if (w_row_full) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            if (w_wr_valid) r_dst[COLS*r_wr +: COLS] <= w_src_row;
            r_wr <= r_wr - 1'b1;
          end
          r_rd <= r_rd - 1'b1;
        end
        COMMIT: begin
          r_field_out <= r_dst;
          r_lines     <= r_cnt;
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.field_out     = r_field_out;
  assign bus.lines_cleared = r_lines;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;

endmodule

// File: tb/tb_field_line_clear.sv
// ---------------------------------------------------------------------------
// tb_field_line_clear
//   Directed bench for field_line_clear. Expected results are built as
//   constants and pushed to a scoreboard queue when an operation is started;
//   they are popped and compared when done is seen.
// ---------------------------------------------------------------------------
module tb_field_line_clear;

  localparam int ROWS  = 20;
  localparam int COLS  = 20;
  localparam int CNT_W = 5;
  localparam int N     = ROWS * COLS;
  localparam int LAT   = ROWS + 1;

  typedef struct {
    logic [N-1:0]     field;
    logic [CNT_W-1:0] lines;
  } exp_t;

  logic clk;
  logic reset;

  field_line_clear_if #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) bus ();

  field_line_clear #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];

  logic [N-1:0]     prev_field;
  logic [CNT_W-1:0] prev_lines;

  logic [N-1:0] f_a, e_a, f_b, e_b, f_c, e_c, f_ones;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] with_row(input logic [N-1:0] f, input int r,
                                            input logic [COLS-1:0] v);
    logic [N-1:0] t;
    t = f;
    t[COLS*r +: COLS] = v;
    return t;
  endfunction

  // Called at a falling edge; leaves the bench at the falling edge after
  // the accepting rising edge (edge count k = 0 in run_to_done).
  task automatic start_op(input logic [N-1:0] f, input logic [N-1:0] ef,
                          input int el);
    exp_t e;
    e.field = ef;
    e.lines = CNT_W'(el);
    sb_q.push_back(e);
    bus.start    = 1'b1;
    bus.field_in = f;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  // Steps falling edges until done, bounded. Optionally pulses start with a
  // different field at edge count poke_k to show it is ignored while busy.
  task automatic run_to_done(input string tag, input int poke_k,
                             input logic [N-1:0] poke_f);
    int   k         = 0;
    int   busy_low  = 0;
    int   hold_bad  = 0;
    exp_t e;
    while (bus.done !== 1'b1 && k < 3 * LAT) begin
      if (bus.busy !== 1'b1) busy_low++;
      if (bus.field_out !== prev_field || bus.lines_cleared !== prev_lines) hold_bad++;
      bus.start = (k == poke_k);
      if (k == poke_k) bus.field_in = poke_f;
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
    check({tag, "_latency"},  N'(k),        N'(LAT));
    check({tag, "_busy_run"}, N'(busy_low), '0);
    check({tag, "_hold"},     N'(hold_bad), '0);
    check({tag, "_busy_end"}, N'(bus.busy), '0);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, N'(1), '0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_field"}, bus.field_out,         e.field);
      check({tag, "_lines"}, N'(bus.lines_cleared), N'(e.lines));
      prev_field = e.field;
      prev_lines = e.lines;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;

    f_ones = '1;
    f_a = with_row(with_row('0, 19, 20'h00001), 10, 20'hABCDE);
    e_a = f_a;
    f_b = with_row(with_row('0, 19, 20'hFFFFF), 18, 20'h00001);
    e_b = with_row('0, 19, 20'h00001);
    f_c = with_row(with_row(with_row(with_row('0, 19, 20'hFFFFF), 17, 20'hFFFFF),
                            18, 20'h0000F), 16, 20'h80000);
    e_c = with_row(with_row('0, 19, 20'h0000F), 18, 20'h80000);

    prev_field   = '0;
    prev_lines   = '0;
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.field_in = '0;

    // Reset state
    #2;
    check("rst_field_out", bus.field_out,         '0);
    check("rst_lines",     N'(bus.lines_cleared), '0);
    check("rst_busy",      N'(bus.busy),          '0);
    check("rst_done",      N'(bus.done),          '0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reset in the middle of SCAN aborts without a done pulse
    start_op(f_ones, '0, 0);
    repeat (10) @(negedge clk);
    check("mid_busy_before", N'(bus.busy), N'(1));
    #1 reset = 1'b0;
    #1;
    check("mid_rst_field", bus.field_out,         '0);
    check("mid_rst_lines", N'(bus.lines_cleared), '0);
    check("mid_rst_busy",  N'(bus.busy),          '0);
    check("mid_rst_done",  N'(bus.done),          '0);
    sb_q.delete();
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    check("mid_no_done", N'(dones), '0);

    start_op('0, '0, 0);
    run_to_done("after_rst", -1, '0);
    @(negedge clk);

    // No full rows: field passes through unchanged
    start_op(f_a, e_a, 0);
    run_to_done("no_full", -1, '0);
    @(negedge clk);
    check("no_full_done_pulse", N'(bus.done), '0);

    // Single bottom clear
    start_op(f_b, e_b, 1);
    run_to_done("single", -1, '0);
    @(negedge clk);

    // Non-adjacent clears
    start_op(f_c, e_c, 2);
    run_to_done("nonadj", -1, '0);
    @(negedge clk);

    // All rows full
    start_op(f_ones, '0, ROWS);
    run_to_done("all_full", -1, '0);
    dones = 0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    check("all_full_done_once", N'(dones), '0);

    // Start while busy is ignored; field_in changes mid-scan have no effect
    start_op(f_a, e_a, 0);
    run_to_done("ign_start", 5, f_ones);
    dones = 0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    check("ign_start_one_done", N'(dones), '0);
    check("ign_start_idle",     N'(bus.busy), '0);

    // Back-to-back: start accepted in the done cycle
    start_op(f_b, e_b, 1);
    run_to_done("b2b_first", -1, '0);
    start_op(f_c, e_c, 2);
    check("b2b_done_width", N'(bus.done), '0);
    check("b2b_busy_again", N'(bus.busy), N'(1));
    run_to_done("b2b_second", -1, '0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/field_line_clear.md
Name: field_line_clear

Overview:
- Consumes the 400-bit playfield that the background register stores after a block lands.
- Scans the playfield row by row and removes every completely filled row.
- Collapses the remaining rows downward and zero-fills the top.
- Returns the compacted field plus the number of cleared rows. The field goes back to the background register's field input; the count goes to scoring.

Parameters:
ROWS, 20, number of playfield rows
COLS, 20, number of playfield columns; ROWS*COLS = 400
CNT_W, 5, width of lines_cleared; must hold ROWS

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle request to process field_in; sampled only in IDLE
field_in  input  ROWS*COLS  playfield to process; captured when start is accepted
field_out  output  ROWS*COLS  compacted playfield; holds until the next commit
lines_cleared  output  CNT_W  number of full rows removed in the last operation; holds
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when field_out and lines_cleared are updated

Behaviour:
- Row mapping:
  - Row r occupies field bits [COLS*r +: COLS].
  - Row 0 is the top row; row ROWS-1 is the bottom row.
  - A row is full when all COLS bits are 1.
- Reset (reset=0, asynchronous):
  - field_out=0, lines_cleared=0, busy=0, done=0.
  - Source buffer, destination buffer, read pointer, write pointer and count cleared.
  - state=IDLE.
  - Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, SCAN, COMMIT.
- IDLE:
  - On start=1 at edge E0:
    - src <= field_in, dst <= 0.
    - rd <= ROWS-1, wr <= ROWS-1, cnt <= 0.
    - busy <= 1, state <= SCAN.
  - start=0: remain in IDLE.
- SCAN, one row per cycle, edges E1..E(ROWS):
  - If src row rd is full: cnt <= cnt+1; wr unchanged.
  - Otherwise: dst row wr <= src row rd; wr <= wr-1.
  - rd <= rd-1 each cycle.
  - When rd==0 is processed, state <= COMMIT.
  - wr must not underflow-wrap into a valid write. If all rows are copied, wr goes below 0 only after the last write; use a pointer one bit wider or a guard.
- COMMIT, edge E(ROWS+1):
  - field_out <= dst, lines_cleared <= cnt.
  - done <= 1, busy <= 0, state <= IDLE.
- done:
  - High for exactly the one cycle after COMMIT.
  - Cleared at the next edge regardless of start.
- Latency: done is high ROWS+1 edges after the start edge, i.e. 21 cycles at default parameters. The latency is fixed and independent of field content.
- Rows in dst above the final wr remain 0 because dst is zeroed at capture.
- start while busy=1 is ignored; there is no queuing and no error flag.
- start in the cycle done is high is accepted, because state is already IDLE.
- field_in is sampled only at acceptance. Changes to field_in during SCAN have no effect.
- field_out and lines_cleared change only at COMMIT or reset.
- Partial rows are copied bit-exact; column order within a row is never altered.
- Count arithmetic is unsigned, CNT_W bits. Maximum value is ROWS, with no saturation required.

Test Plan:
- Reset mid-operation:
  - Stimulus: assert reset low during SCAN at the 10th row.
  - Required: all outputs 0 immediately (asynchronous), no done pulse. A subsequent start with field_in=0 yields done at 21 cycles, field_out=0, lines_cleared=0.
- No full rows:
  - Stimulus: row 19=20'h00001, row 10=20'hABCDE, others 0.
  - Required: field_out equals field_in, lines_cleared=0. done exactly 21 cycles after the start edge; busy high for cycles 1..21.
- Single bottom clear:
  - Stimulus: row 19=20'hFFFFF, row 18=20'h00001, others 0.
  - Required: field_out row 19=20'h00001, all other rows 0, lines_cleared=1.
- Non-adjacent clears:
  - Stimulus: rows 19 and 17=20'hFFFFF, row 18=20'h0000F, row 16=20'h80000, others 0.
  - Required: row 19=20'h0000F, row 18=20'h80000, rows 0..17=0, lines_cleared=2.
- All full:
  - Stimulus: field_in all ones.
  - Required: field_out=0, lines_cleared=20, done once.
- Back-to-back and ignored start:
  - Stimulus: start pulsed again at cycle 5 of an operation.
  - Required: ignored; only one done.
  - Stimulus: start in the done cycle with a new field.
  - Required: accepted; second done 21 cycles later with the correct result. field_out holds the first result until the second commit.
